// File: rtl/cyclic_meggitt_decoder_if.sv
// ---------------------------------------------------------------------------
// cyclic_meggitt_decoder_if
// Handshake bundle between the channel deframer (master), the Meggitt
// decoder (slave) and the payload extractor downstream.
//   in_valid / in_ready / in_data        : received word, ready/valid
//   out_valid / out_ready / out_data     : decoded word, ready/valid
//   err_corrected / err_uncorrectable    : status qualified by out_valid
// ---------------------------------------------------------------------------
interface cyclic_meggitt_decoder_if #(
  parameter int N = 7
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         err_corrected;
  logic         err_uncorrectable;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_corrected, err_uncorrectable
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, err_corrected, err_uncorrectable
  );
endinterface

// File: rtl/cyclic_meggitt_decoder.sv
// ---------------------------------------------------------------------------
// cyclic_meggitt_decoder
// Serial Meggitt decoder for single-error-correcting binary cyclic codes
// (N, N-R) with generator GPOLY. One word is accepted, its syndrome is built
// one bit per clock (highest-order bit first); a nonzero syndrome triggers a
// second N-cycle pass that rotates the syndrome and flips the bit whose
// position matches x^(N-1) mod GPOLY. Clean words skip that pass.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any word in flight
//   bus  : slave side of cyclic_meggitt_decoder_if (in/out ready-valid,
//          decoded word, err_corrected, err_uncorrectable)
// ---------------------------------------------------------------------------
module cyclic_meggitt_decoder #(
  parameter int           N     = 7,
  parameter int           R     = 3,
  parameter logic [R:0]   GPOLY = 4'b1011
) (
  input  logic                      clk,
  input  logic                      rst,
  cyclic_meggitt_decoder_if.slave   bus
);

  localparam int             CW      = $clog2(N);
  localparam logic [CW-1:0]  CNT_MAX = CW'(N - 1);
  localparam logic [R-1:0]   POLY_LO = GPOLY[R-1:0];

  // One LFSR step: multiply by x, shift in b, reduce modulo GPOLY.
  function automatic logic [R-1:0] step(input logic [R-1:0] s, input logic b);
    step = {s[R-2:0], b} ^ (s[R-1] ? POLY_LO : '0);
  endfunction

  // x^p mod GPOLY, evaluated at elaboration.
  function automatic logic [R-1:0] xpow_mod(input int p);
    logic [R-1:0] r;
    r = R'(1);
    for (int i = 0; i < p; i++) r = step(r, 1'b0);
    return r;
  endfunction

  // Syndrome of a single error in the highest-order position.
  localparam logic [R-1:0] S_TOP = xpow_mod(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  rx_buf;
  logic [N-1:0]  out_data;
  logic [R-1:0]  s;
  logic [CW-1:0] cnt;
  logic          err_c, err_u;

  logic [R-1:0]  s_calc;
  logic [R-1:0]  s_corr;
  logic          e;
  logic          last;

  assign last   = (cnt == '0);
  assign s_calc = step(s, rx_buf[cnt]);
  assign e      = (s == S_TOP);
  // Clearing S_TOP on a match zeroes s, so no further bit can fire.
  assign s_corr = step(s ^ (e ? S_TOP : '0), 1'b0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)  state_nxt = CALC;
      CALC: if (last)          state_nxt = (s_calc == '0) ? DONE : CORR;
      CORR: if (last)          state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf   <= '0;
      out_data <= '0;
      s        <= '0;
      cnt      <= '0;
      err_c    <= 1'b0;
      err_u    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rx_buf <= bus.in_data;
            s      <= '0;
            cnt    <= CNT_MAX;
            err_c  <= 1'b0;
            err_u  <= 1'b0;
          end
        end
        CALC: begin
          s <= s_calc;
          if (last) begin
            // Preload the output; the correction pass rewrites it bit by bit.
            out_data <= rx_buf;
            if (s_calc != '0) cnt <= CNT_MAX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CORR: begin
          s             <= s_corr;
          out_data[cnt] <= rx_buf[cnt] ^ e;
          if (e) err_c <= 1'b1;
          if (last) err_u <= (s_corr != '0);
          else      cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready          = (state == IDLE);
  assign bus.out_valid         = (state == DONE);
  assign bus.out_data          = out_data;
  assign bus.err_corrected     = err_c;
  assign bus.err_uncorrectable = err_u;

endmodule
